sm3_pad: RTL
============

// Module: sm3_pad
// PURPOSE
//  Streaming SM3 message padder; sits directly upstream of the sm3 compression datapath.
//  Accepts a message as big-endian 32-bit words over valid/ready and emits padded 512-bit blocks, one per handshake.
//  Padding: 0x80, then zeros, then the 64-bit big-endian message bit length.
//  Block bit/byte layout is identical to the sm3 data port: first message byte at [511:504].
// PARAMETERS
//  LEN_W   64  width of internal bit-length counter (<=64); zero-extended into the length field
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input word valid
//  in_ready   out  1    padder can accept a word
//  in_data    in   32   message word, first byte in [31:24]
//  in_last    in   1    final word of message
//  in_nbytes  in   3    valid bytes in word (0..4), MSB-aligned; honoured only when in_last, else 4
//  out_valid  out  1    out_block valid
//  out_ready  in   1    downstream accepts block
//  out_block  out  512  padded block
//  out_last   out  1    block is final block of message
// BEHAVIOUR
//  One clock, async active-low reset. Reset: out_valid=0, out_block=0, out_last=0, state=S_FILL, widx=0, len=0.
//  in_ready=1 iff state==S_FILL (also during and right after reset); input/output never overlap.
//  States:
//  - S_FILL: each in_valid&in_ready writes word at widx, widx++, len+=8*bytes.
//    - not last and widx reaches 16 -> S_OUT, out_last=0.
//    - last: b = bytes in block incl. final word (0..64).
//      - b<=55: 0x80 at byte b, zeros, len at bytes 56..63 -> S_OUT, out_last=1.
//      - 56<=b<=63: 0x80 at byte b, zero rest -> S_OUT, out_last=0, tail pending (no 0x80).
//      - b==64: -> S_OUT, out_last=0, tail pending (0x80 needed).
//  - S_OUT: out_valid=1; out_block/out_last held stable until out_ready.
//    - on handshake: tail pending -> S_TAIL; else -> S_FILL with buffer zeroed, widx=0.
//    - len cleared only after the out_last=1 handshake.
//  - S_TAIL: one cycle builds {opt 0x80, zeros, len} -> S_OUT, out_last=1.
//  Latency: out_valid rises the cycle after the accepting edge (registered). Tail block out_valid is 2 cycles after the prior handshake.
//  Bytes of a partial last word beyond in_nbytes are ignored (treated as zero before 0x80 insertion).
//  in_nbytes=0 with in_last: no data bytes; an empty message gives 0x80 00..00 with length 0.
//  Length overflow beyond 2^LEN_W-1 bits wraps silently; not flagged.
//  out_ready high while out_valid low: no effect. Reset mid-message discards all state.
// STRUCTURE
//  sm3_pkg: SM3_BLOCK_W=512, SM3_LEN_FIELD_W=64, state enum {S_FILL,S_OUT,S_TAIL}.
//  sm3_pkg also holds function pad_insert(block,byte_pos) that places 0x80 and zeros the tail.
//  No sub-module; single always_ff FSM plus combinational byte-insert mux.
// TESTING
//  1 "abc": one word 32'h61626300, nbytes=3, last -> one block 512'h61626380_0..0_00000018, out_last=1.
//    Fed to sm3 NUM=1 -> 66c7f0f4...8f4ba8e0.
//  2 16x 32'h61626364, last on 16th (b=64) -> blk0 = 16 data words, last=0.
//    blk1 = 80000000_0..0_00000200, last=1; both to sm3 NUM=2 -> debe9ff9...9c0c5732.
//  3 empty: nbytes=0, last -> 512'h80000000_0..0, out_last=1.
//  4 14x 32'h61626364 (b=56) -> blk0 = data + 32'h80000000 + 0x00000000, last=0.
//    blk1 = zeros..000001C0, last=1.
//  5 backpressure: out_ready low 5 cycles during case 1.
//    -> out_block/out_last stable, in_ready=0, in_valid words not consumed.
//  6 rst_n low after 5 accepted words -> out_valid=0, in_ready=1; then rerun case 1 -> identical result.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 message padder: block geometry, the FSM
// state type and the 0x80 terminator insertion helper.
package sm3_pkg;

  localparam int SM3_BLOCK_W     = 512;
  localparam int SM3_LEN_FIELD_W = 64;

  typedef enum logic [1:0] {
    S_FILL,
    S_OUT,
    S_TAIL
  } state_t;

  // Writes 0x80 at byte byte_pos (byte 0 sits at [511:504]) and clears every
  // later byte. Earlier bytes are kept. A byte_pos of 64 leaves the block as is.
  function automatic logic [SM3_BLOCK_W-1:0] pad_insert(
    input logic [SM3_BLOCK_W-1:0] block,
    input logic [6:0]             byte_pos
  );
    logic [SM3_BLOCK_W-1:0] r;
    r = block;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) == byte_pos) begin
        r[511-8*i -: 8] = 8'h80;
      end else if (7'(i) > byte_pos) begin
        r[511-8*i -: 8] = 8'h00;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sm3_pad_if.sv
// Handshake bundle for the SM3 padder: word input stream and block output
// stream. The padder itself connects through the slave modport.
interface sm3_pad_if;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_block, out_last
  );

endinterface

// File: rtl/sm3_pad.sv
// Streaming SM3 message padder. Collects big-endian 32-bit words into a
// 512-bit buffer and emits padded blocks with 0x80, zero fill and the 64-bit
// message bit length. A tail block is produced when the terminator or the
// length field does not fit into the final data block.
module sm3_pad
  import sm3_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input logic   clk,
  input logic   rst_n,
  sm3_pad_if.slave bus
);

  state_t                 state_q, state_d;
  logic [4:0]             widx_q, widx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [SM3_BLOCK_W-1:0] fill_q, fill_d;
  logic [SM3_BLOCK_W-1:0] blk_q, blk_d;
  logic                   last_q, last_d;
  logic                   tail_q, tail_d;
  logic                   tail80_q, tail80_d;

  logic [2:0]             nb;
  logic [31:0]            word_m;
  logic [SM3_BLOCK_W-1:0] fill_w;
  logic [LEN_W-1:0]       len_w;
  logic [6:0]             b_pos;

  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_block = blk_q;
  assign bus.out_last  = last_q;

  // Word merge, terminator placement and next-state selection.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    len_d    = len_q;
    fill_d   = fill_q;
    blk_d    = blk_q;
    last_d   = last_q;
    tail_d   = tail_q;
    tail80_d = tail80_q;

    // Only the final word may be short; oversize counts saturate at a full word.
    if (bus.in_last) begin
      nb = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
    end else begin
      nb = 3'd4;
    end

    word_m = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < nb) begin
        word_m[31-8*j -: 8] = bus.in_data[31-8*j -: 8];
      end
    end

    fill_w = fill_q;
    for (int w = 0; w < 16; w++) begin
      if (widx_q == 5'(w)) begin
        fill_w[511-32*w -: 32] = word_m;
      end
    end

    len_w = len_q + LEN_W'({nb, 3'b000});
    b_pos = {widx_q, 2'b00} + {4'b0000, nb};

    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          len_d = len_w;
          if (!bus.in_last) begin
            if (widx_q == 5'd15) begin
              state_d = S_OUT;
              blk_d   = fill_w;
              last_d  = 1'b0;
              tail_d  = 1'b0;
            end else begin
              fill_d = fill_w;
              widx_d = widx_q + 5'd1;
            end
          end else begin
            state_d = S_OUT;
            if (b_pos <= 7'd55) begin
              blk_d        = pad_insert(fill_w, b_pos);
              blk_d[63:0]  = 64'(len_w);
              last_d       = 1'b1;
              tail_d       = 1'b0;
            end else if (b_pos <= 7'd63) begin
              blk_d    = pad_insert(fill_w, b_pos);
              last_d   = 1'b0;
              tail_d   = 1'b1;
              tail80_d = 1'b0;
            end else begin
              blk_d    = fill_w;
              last_d   = 1'b0;
              tail_d   = 1'b1;
              tail80_d = 1'b1;
            end
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (tail_q) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FILL;
            fill_d  = '0;
            widx_d  = '0;
            if (last_q) begin
              len_d = '0;
            end
          end
        end
      end
      S_TAIL: begin
        blk_d          = '0;
        blk_d[511:504] = tail80_q ? 8'h80 : 8'h00;
        blk_d[63:0]    = 64'(len_q);
        last_d         = 1'b1;
        tail_d         = 1'b0;
        state_d        = S_OUT;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and datapath registers; reset drops any partially collected message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      widx_q   <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      tail_q   <= 1'b0;
      tail80_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      blk_q    <= blk_d;
      last_q   <= last_d;
      tail_q   <= tail_d;
      tail80_q <= tail80_d;
    end
  end

endmodule
